// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// State encodings and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a parameterized reset value.
// Brings an asynchronous line into the clk domain.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output.
// Flags framing errors and overruns as one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxs;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rxs)
  );

  // Frame FSM: mid-bit sampling, shift-in, and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
              if (!valid || ready) begin
                data_out <= shreg;
                valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1 asynchronous serial frames from line `rxd` and presents each byte on a valid/ready parallel output. It is the receive end of the team's serial link and pairs with the UART transmitter on the same clock domain. Input is synchronized internally. Framing errors and overruns are flagged as single-cycle pulses.

## Interface

- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be even and at least 4.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rxd`  in  1  serial line, asynchronous to clk, idles high.
- `data_out`  out  DATA_BITS  received byte, stable while `valid`=1.
- `valid`  out  1  byte available.
- `ready`  in  1  consumer accepts the byte when `valid`&&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a new byte was dropped because the previous byte was still unaccepted.

## Operation

- **Synchronizer:** 2-flop, both flops reset to 1. Its output is `rxs`. All logic uses `rxs` only.
- **Reset values:**
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - `data_out`=0, `valid`=0, `frame_err`=0, `overrun`=0.
- **IDLE:** if `rxs`=0, go to START with cnt=0.
- **START:** cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1, sample `rxs`:
  - `rxs`=0: go to DATA with cnt=0 and bit index=0.
  - `rxs`=1: glitch; go to IDLE with no output.
- **DATA:** at cnt==CLKS_PER_BIT-1, sample `rxs`, shift it into the MSB of the shift register (right shift), reset cnt, and increment bit index. After DATA_BITS samples, go to STOP.
- **STOP:** at cnt==CLKS_PER_BIT-1, sample `rxs`:
  - `rxs`=1, and either `valid`=0 or `ready`=1 this cycle: load `data_out` from the shift register, set `valid`=1, go to IDLE.
  - `rxs`=1, `valid`=1 and `ready`=0: pulse `overrun`; `data_out`/`valid` stay unchanged and the new byte is discarded; go to IDLE.
  - `rxs`=0: pulse `frame_err`, no load, go to BREAK.
- **BREAK:** wait for `rxs`=1, then go to IDLE. This prevents a held-low line from retriggering.
- **Handshake:**
  - `valid` clears on a cycle where `valid`&&`ready` is true, unless a new byte loads that same cycle, in which case `valid` stays 1 with the new data.
  - `ready` may be held high permanently.
- **Async reset mid-frame:** immediate return to reset values; any partial frame is discarded.

## Timing

- Let edge 0 be the clk edge at which the first synchronizer flop captures the falling start edge. Then:
  - IDLE→START at edge 2.
  - Start bit sampled at edge 2+CLKS_PER_BIT/2.
  - Data bit i sampled at edge 2+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled, and `valid`/`data_out` update, at edge 2+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT. With the defaults this is edge 154.
- `frame_err` and `overrun` are high for exactly one cycle, at the stop-sample edge.
- Back-to-back frames: a start edge arriving immediately after the stop sample is detected from IDLE with no lost cycle.
- Tolerated baud mismatch: ±3% at CLKS_PER_BIT=16.

## Structure

- **Shared package/header `uart_pkg`, used with the transmitter:**
  - state encodings IDLE, START, DATA, STOP, BREAK;
  - default CLKS_PER_BIT and DATA_BITS constants.
- **One sub-module, `sync_2ff`:** two async-reset flip-flops with reset value parameterized (1 here), instantiated for `rxd`.
- **Counter widths:** clog2(CLKS_PER_BIT) for the cycle counter, clog2(DATA_BITS+1) for the bit index.

## Test plan

- **Single byte:** `ready`=1, send 0xA5 at 16 clk/bit → `data_out`=0xA5, `valid` rises at edge 154 and is high for 1 cycle.
- **Glitch:** `rxd` low for 4 cycles, then high → no `valid`, no `frame_err`, state back in IDLE.
- **Framing error:** send 0x3C with stop bit low, then hold `rxd` low for 40 bits → exactly one `frame_err` pulse, no `valid`. After `rxd` returns high, 0x81 is received correctly.
- **Overrun:** `ready`=0, send 0x11 then 0x22 → `valid`=1 with 0x11, one `overrun` pulse at the second stop sample. Raising `ready` → 0x11 is accepted and `valid` drops.
- **Simultaneous accept/load:** pulse `ready` exactly on the second frame's stop-sample edge → no `overrun`, `valid` stays 1, `data_out` becomes 0x22.
- **Reset mid-frame:** assert `rst` during data bit 3 → all outputs 0 immediately. After release, the next 0x5A frame is received intact.
